// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Requester count, grant-id width, FSM state encoding and one-hot decode.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned ID_W  = 2;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [N_REQ-1:0] r;
      r     = '0;
      r[id] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Rotating priority encoder: picks the first set request after ptr,
// wrapping so that ptr itself is examined last.
module rr_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   logic [ID_W-1:0]    s;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [ID_W-1:0]    enc;
   logic               found;

   always_comb begin
      s     = ptr + ID_W'(1);
      dbl   = {req, req};
      rot   = dbl[s +: N_REQ];
      enc   = '0;
      found = 1'b0;
      // Lowest rotated bit wins; rotation puts ptr+1 at bit 0.
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (rot[i] && !found) begin
            enc   = ID_W'(i);
            found = 1'b1;
         end
      end
      id  = enc + s;
      any = |req;
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 4 requesters with grant hold and optional
// preemption after MAX_HOLD consecutive cycles.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic             timeout
);

   localparam int unsigned HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int unsigned HOLD_SAT  = (MAX_HOLD > 0) ? MAX_HOLD : 0;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [HW-1:0]   hold_cnt;
   logic [ID_W-1:0] pick_id;
   logic            pick_any;
   logic            holder_req;
   logic            hold_last;
   logic            do_pick;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr),
      .id  (pick_id),
      .any (pick_any)
   );

   // ptr always equals the current holder while granted, so one picker
   // serves idle arbitration, release hand-off and preemption alike.
   always_comb begin
      holder_req = req[grant_id];
      hold_last  = (MAX_HOLD > 0) && (hold_cnt == HW'(HOLD_LAST));
      do_pick    = (state == ST_IDLE) || !holder_req || hold_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '1;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         if (do_pick) begin
            if (pick_any) begin
               state    <= ST_GRANT;
               grant    <= onehot(pick_id);
               grant_id <= pick_id;
               busy     <= 1'b1;
               ptr      <= pick_id;
               hold_cnt <= '0;
               timeout  <= (state == ST_GRANT) && holder_req;
            end else begin
               state    <= ST_IDLE;
               grant    <= '0;
               grant_id <= '0;
               busy     <= 1'b0;
               hold_cnt <= '0;
            end
         end else if (hold_cnt != HW'(HOLD_SAT)) begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (MAX_HOLD=8) plus an exhaustive
// check of the rr_pick encoder against a search-order model.
module tb_rr_grant_arbiter;
   import arb_pkg::*;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] id;
      logic       busy;
      logic       to;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] id;
      logic       busy;
      logic       to;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout;

   logic [3:0] pk_req = '0;
   logic [1:0] pk_ptr = '0;
   logic [1:0] pk_id;
   logic       pk_any;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[$];
   exp_t sb[$];

   rr_grant_arbiter #(.MAX_HOLD(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   rr_pick u_pick (
      .req (pk_req),
      .ptr (pk_ptr),
      .id  (pk_id),
      .any (pk_any)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                               input logic [1:0] i, input logic b, input logic t);
      vec_t v;
      v.rst = r; v.req = q; v.grant = g; v.id = i; v.busy = b; v.to = t;
      vecs.push_back(v);
   endfunction

   function automatic void add_n(input int n, input logic [3:0] q, input logic [3:0] g,
                                 input logic [1:0] i);
      for (int k = 0; k < n; k++) add(1'b0, q, g, i, 1'b1, 1'b0);
   endfunction

   initial begin
      exp_t e;
      exp_t got;
      int   m_id;
      logic m_any;
      logic [3:0] vr;
      logic [1:0] vp;
      logic [1:0] cand;

      // Reset then single request
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0100, 4'b0100, 2, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // Priority after reset, release hand-off, reset mid-grant
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b1010, 4'b0010, 1, 1, 0);
      add(0, 4'b1000, 4'b1000, 3, 1, 0);
      add(1, 4'b1000, 4'b0000, 0, 0, 0);
      add(0, 4'b1001, 4'b0001, 0, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // Fairness: each holder keeps 2 cycles then drops its bit
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 1, 0);
      add(0, 4'b1111, 4'b0001, 0, 1, 0);
      add(0, 4'b1110, 4'b0010, 1, 1, 0);
      add(0, 4'b1111, 4'b0010, 1, 1, 0);
      add(0, 4'b1101, 4'b0100, 2, 1, 0);
      add(0, 4'b1111, 4'b0100, 2, 1, 0);
      add(0, 4'b1011, 4'b1000, 3, 1, 0);
      add(0, 4'b1111, 4'b1000, 3, 1, 0);
      add(0, 4'b0111, 4'b0001, 0, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // Timeout preemption with two steady requesters
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0011, 4'b0001, 0, 1, 0);
      add_n(7, 4'b0011, 4'b0001, 0);
      add(0, 4'b0011, 4'b0010, 1, 1, 1);
      add_n(7, 4'b0011, 4'b0010, 1);
      add(0, 4'b0011, 4'b0001, 0, 1, 1);
      add_n(7, 4'b0011, 4'b0001, 0);
      // Release on the would-be timeout cycle: no pulse
      add(0, 4'b0010, 4'b0010, 1, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      // Sole holder: re-granted with a timeout pulse every 8 cycles
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0001, 4'b0001, 0, 1, 0);
      for (int r = 0; r < 2; r++) begin
         add_n(7, 4'b0001, 4'b0001, 0);
         add(0, 4'b0001, 4'b0001, 0, 1, 1);
      end
      add(0, 4'b0000, 4'b0000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         req = vecs[i].req;
         e.grant = vecs[i].grant; e.id = vecs[i].id;
         e.busy = vecs[i].busy; e.to = vecs[i].to; e.idx = i;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", i);
         end else begin
            got = sb.pop_front();
            chk("grant",    got.idx, int'(grant),    int'(got.grant));
            chk("grant_id", got.idx, int'(grant_id), int'(got.id));
            chk("busy",     got.idx, int'(busy),     int'(got.busy));
            chk("timeout",  got.idx, int'(timeout),  int'(got.to));
         end
      end

      // rr_pick: all 64 req/ptr combinations
      for (int v = 0; v < 64; v++) begin
         vr = 4'(v);
         vp = 2'(v >> 4);
         pk_req = vr;
         pk_ptr = vp;
         #1;
         m_any = 1'b0;
         m_id  = 0;
         for (int k = 1; k <= 4; k++) begin
            cand = vp + 2'(k);
            if (!m_any && vr[cand]) begin
               m_any = 1'b1;
               m_id  = int'(cand);
            end
         end
         chk("pick_any", v, int'(pk_any), int'(m_any));
         if (m_any) chk("pick_id", v, int'(pk_id), m_id);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
